instr_fetch_unit: RTL

Front-end fetch controller that consumes the program counter and drives its next value. It issues one instruction-memory read per PC value, buffers returned instructions with their PC in a small FIFO toward decode, and handles redirects from later stages. It sits between the PC register (driving its write enable and data input) and the decode stage.

---
 rtl/instr_fetch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch controller: drives the PC register, issues one imem read per PC,
// and buffers {fault, pc, instr} toward decode in a small FIFO with redirect flush.
`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module instr_fetch_unit #(
   parameter int XLEN     = `XLEN_64b,
   parameter int FQ_DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_clk_en,
   input  logic [(1<<(XLEN+4))-1:0]   i_pc,
   output logic                       o_pc_wr_en,
   output logic [(1<<(XLEN+4))-1:0]   o_pc_next,
   input  logic                       i_redirect,
   input  logic [(1<<(XLEN+4))-1:0]   i_redirect_pc,
   output logic                       o_imem_req_valid,
   input  logic                       i_imem_req_ready,
   output logic [(1<<(XLEN+4))-1:0]   o_imem_addr,
   input  logic                       i_imem_rsp_valid,
   input  logic [31:0]                i_imem_rsp_data,
   input  logic                       i_imem_rsp_err,
   output logic                       o_if_valid,
   input  logic                       i_if_ready,
   output logic [31:0]                o_if_instr,
   output logic [(1<<(XLEN+4))-1:0]   o_if_pc,
   output logic                       o_if_fault,
   output logic [1:0]                 o_dbg_state
);

   localparam int AW = 1 << (XLEN + 4);
   localparam int PW = $clog2(FQ_DEPTH);
   localparam int CW = PW + 1;

   // Handshakes: a request transfers on a cycle where o_imem_req_valid and i_imem_req_ready
   // are both high; a queue entry transfers on o_if_valid and i_if_ready both high.
   typedef enum logic [1:0] {REQ, WAIT, DROP, HALT} state_t;

   state_t          state;
   logic [31:0]     q_instr [FQ_DEPTH];
   logic [AW-1:0]   q_pc    [FQ_DEPTH];
   logic            q_fault [FQ_DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic [AW-1:0]   req_pc;

   logic            live;
   logic            in_flight;
   logic            space;
   logic            aligned;
   logic            req_fire;
   logic            fault_push;
   logic            rsp_push;
   logic            push;
   logic            pop;
   logic            push_fault;
   logic [AW-1:0]   push_pc;
   logic [31:0]     push_instr;

   always_comb begin
      live       = i_rst_n & i_clk_en;
      in_flight  = (state == WAIT) || (state == DROP);
      // An outstanding request reserves a slot so its response can never overflow.
      space      = (count + CW'(in_flight)) < CW'(FQ_DEPTH);
      aligned    = (i_pc[1:0] == 2'b00);

      o_imem_req_valid = live & ~i_redirect & (state == REQ) & space & aligned;
      req_fire         = o_imem_req_valid & i_imem_req_ready;
      fault_push       = live & ~i_redirect & (state == REQ) & space & ~aligned;
      rsp_push         = live & ~i_redirect & (state == WAIT) & i_imem_rsp_valid;
      push             = fault_push | rsp_push;
      pop              = live & ~i_redirect & o_if_valid & i_if_ready;

      o_pc_wr_en = live & (i_redirect | req_fire);
      o_pc_next  = '0;
      if (live && i_redirect) begin
         o_pc_next = i_redirect_pc;
      end else if (req_fire) begin
         o_pc_next = i_pc + AW'(4);
      end
      o_imem_addr = i_pc;

      push_fault = fault_push ? 1'b1  : i_imem_rsp_err;
      push_pc    = fault_push ? i_pc  : req_pc;
      push_instr = fault_push ? 32'h0 : i_imem_rsp_data;
   end

   assign o_if_valid  = (count != '0);
   assign o_if_instr  = q_instr[rd_ptr];
   assign o_if_pc     = q_pc[rd_ptr];
   assign o_if_fault  = q_fault[rd_ptr];
   assign o_dbg_state = state;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= REQ;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         req_pc <= '0;
         for (int i = 0; i < FQ_DEPTH; i++) begin
            q_instr[i] <= '0;
            q_pc[i]    <= '0;
            q_fault[i] <= 1'b0;
         end
      end else if (i_clk_en) begin
         if (i_redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // A response arriving with the redirect is consumed here, so no drop is needed.
            case (state)
               WAIT, DROP: state <= i_imem_rsp_valid ? REQ : DROP;
               default:    state <= REQ;
            endcase
         end else begin
            if (push) begin
               q_instr[wr_ptr] <= push_instr;
               q_pc[wr_ptr]    <= push_pc;
               q_fault[wr_ptr] <= push_fault;
               wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            case (state)
               REQ: begin
                  if (req_fire) begin
                     req_pc <= i_pc;
                     state  <= WAIT;
                  end else if (fault_push) begin
                     state  <= HALT;
                  end
               end
               WAIT:    if (i_imem_rsp_valid) state <= REQ;
               DROP:    if (i_imem_rsp_valid) state <= REQ;
               default: state <= HALT;
            endcase
         end
      end
   end

endmodule
